// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit scheduler.
package uart_pkg;

  localparam int unsigned WORD_LENGTH_DEF = 8;
  localparam int unsigned MAX_BURST_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_START = 2'd2,
    ST_SEND  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first active request after last_grant, wrapping to 0.
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [IDW-1:0]     grant_c,
  output logic               any_req_c
);

  int idx;

  // Walk candidates farthest-first so the nearest one after last_grant wins.
  always_comb begin
    grant_c   = '0;
    any_req_c = 1'b0;
    idx       = 0;
    for (int k = int'(NUM_REQ); k > 0; k--) begin
      idx = (int'(last_grant) + k) % int'(NUM_REQ);
      if (req[IDW'(idx)]) begin
        grant_c   = IDW'(idx);
        any_req_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Multi-requester scheduler feeding one UART transmitter with bounded bursts and a start timeout.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned WORD_LENGTH   = WORD_LENGTH_DEF,
  parameter int unsigned MAX_BURST     = MAX_BURST_DEF,
  parameter int unsigned START_TIMEOUT = 65535
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*WORD_LENGTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_start,
  output logic [WORD_LENGTH-1:0]         tx_data,
  input  logic                           tx_ready,
  output logic                           grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           err_timeout
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned TW  = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  sched_state_t     state;
  logic [IDW-1:0]   last_grant;
  logic [7:0]       burst_cnt;
  logic [TW-1:0]    tmo_cnt;
  logic             last_q;

  logic [IDW-1:0]   arb_grant;
  logic             any_req;

  logic [WORD_LENGTH-1:0] data_arr [NUM_REQ];
  logic                   sel_valid;
  logic                   sel_last;
  logic [WORD_LENGTH-1:0] sel_data;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*WORD_LENGTH +: WORD_LENGTH];
  end

  assign sel_valid = req_valid[grant_id];
  assign sel_last  = req_last[grant_id];
  assign sel_data  = data_arr[grant_id];

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant_c    (arb_grant),
    .any_req_c  (any_req)
  );

  // Scheduler FSM: grant, fetch one character, hand it to the transmitter, decide on release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      req_ready   <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      err_timeout <= 1'b0;
      burst_cnt   <= 8'd0;
      tmo_cnt     <= '0;
      last_q      <= 1'b0;
      last_grant  <= IDW'(NUM_REQ - 1);
    end else begin
      err_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant_id    <= arb_grant;
            grant_valid <= 1'b1;
            req_ready   <= NUM_REQ'(1) << arb_grant;
            state       <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (sel_valid) begin
            tx_data   <= sel_data;
            last_q    <= sel_last;
            burst_cnt <= burst_cnt + 8'd1;
            req_ready <= '0;
            tx_start  <= 1'b1;
            tmo_cnt   <= '0;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (!tx_ready) begin
            tx_start <= 1'b0;
            state    <= ST_SEND;
          end else if (tmo_cnt == TW'(START_TIMEOUT - 1)) begin
            // Transmitter never took the start: drop the rest of the message.
            tx_start    <= 1'b0;
            err_timeout <= 1'b1;
            burst_cnt   <= 8'd0;
            last_grant  <= grant_id;
            grant_valid <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_SEND: begin
          if (tx_ready) begin
            if (last_q || (burst_cnt == 8'(MAX_BURST))) begin
              burst_cnt   <= 8'd0;
              last_grant  <= grant_id;
              grant_valid <= 1'b0;
              state       <= ST_IDLE;
            end else begin
              req_ready <= NUM_REQ'(1) << grant_id;
              state     <= ST_FETCH;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: queue-based requesters, transmitter model, round-robin reference.
module tb_uart_tx_sched;

  localparam int unsigned NR  = 4;
  localparam int unsigned WL  = 8;
  localparam int unsigned MB  = 4;
  localparam int unsigned TMO = 100;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR*WL-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic            tx_start;
  logic [WL-1:0]   tx_data;
  logic            tx_ready;
  logic            grant_valid;
  logic [$clog2(NR)-1:0] grant_id;
  logic            err_timeout;

  typedef struct packed { logic [7:0] d; logic last; } ch_t;
  typedef struct packed { logic [7:0] id; logic [7:0] d; } tx_t;
  typedef struct packed { logic [7:0] id; logic [7:0] n; } gr_t;

  ch_t rq [NR][$];
  tx_t exp_tx [$];
  gr_t exp_gr [$];

  int  vectors = 0;
  int  errors  = 0;
  int  m_last_grant = NR - 1;
  bit  tmo_mode = 1'b0;
  bit  pause_en = 1'b0;
  bit  force_pause = 1'b0;
  int  pause_left [NR];
  logic [NR-1:0] hs;
  time hs_t = 0;
  int  err_cnt = 0;
  bit  tx_busy = 1'b0;
  int  txc = 0;

  uart_tx_sched #(
    .NUM_REQ       (NR),
    .WORD_LENGTH   (WL),
    .MAX_BURST     (MB),
    .START_TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit any_rq();
    for (int i = 0; i < NR; i++) if (rq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic load(input int id, input logic [7:0] d, input logic l);
    ch_t c;
    c.d = d;
    c.last = l;
    rq[id].push_back(c);
  endtask

  // Reference: serve queues round-robin, at most 'limit' chars per grant, stop at a last marker.
  task automatic predict(input int limit, output int ngr);
    ch_t mq [NR][$];
    ch_t c;
    tx_t t;
    gr_t g;
    int  lg, sel, n;
    bit  found;
    ngr = 0;
    for (int i = 0; i < NR; i++) mq[i] = rq[i];
    lg = m_last_grant;
    forever begin
      found = 1'b0;
      sel = 0;
      for (int k = 1; k <= NR; k++) begin
        if (!found && mq[(lg + k) % NR].size() > 0) begin
          found = 1'b1;
          sel = (lg + k) % NR;
        end
      end
      if (!found) break;
      n = 0;
      do begin
        c = mq[sel].pop_front();
        t.id = 8'(sel);
        t.d  = c.d;
        exp_tx.push_back(t);
        n++;
      end while (!c.last && n < limit && mq[sel].size() > 0);
      g.id = 8'(sel);
      g.n  = 8'(n);
      exp_gr.push_back(g);
      ngr++;
      lg = sel;
    end
    m_last_grant = lg;
  endtask

  task automatic wait_phase(input string tag);
    int t = 0;
    while ((exp_tx.size() > 0 || exp_gr.size() > 0 || grant_valid || tx_busy || any_rq())
           && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done"}, 32'(t < 20000), 1);
    repeat (2) @(negedge clk);
    #2;
  endtask

  // Transmitter: takes tx_ready low 3 clocks after a start, keeps it low 20 clocks.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        tx_ready = 1'b1;
        tx_busy  = 1'b0;
      end else if (!tmo_mode) begin
        if (!tx_busy && tx_start) begin
          tx_busy = 1'b1;
          txc = 0;
        end
        if (tx_busy) begin
          txc++;
          if (txc == 3) tx_ready = 1'b0;
          if (txc == 23) begin
            tx_ready = 1'b1;
            tx_busy  = 1'b0;
          end
        end
      end
    end
  end

  // Requesters: present queue heads, pop on handshake, optionally pause while owning the grant.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    hs = '0;
    for (int i = 0; i < NR; i++) pause_left[i] = 0;
    forever begin
      @(negedge clk);
      if (reset) hs = '0;
      for (int i = 0; i < NR; i++) begin
        if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (reset) begin
          pause_left[i] = 0;
        end else if (pause_left[i] > 0) begin
          chk("pause_rdy", 32'(req_ready[i]), 1);
          chk("pause_gid", 32'(grant_id), 32'(i));
          chk("pause_tx", 32'(tx_start), 0);
          pause_left[i]--;
        end else if (req_ready[i] && rq[i].size() > 0) begin
          if (force_pause && i == 2 && rq[2].size() == 2) begin
            pause_left[i] = 50;
            force_pause = 1'b0;
          end else if (pause_en && $urandom_range(0, 5) == 0) begin
            pause_left[i] = int'($urandom_range(1, 12));
          end
        end
        req_valid[i] = (rq[i].size() > 0) && (pause_left[i] == 0);
        if (rq[i].size() > 0) begin
          req_data[i*WL +: WL] = rq[i][0].d;
          req_last[i] = rq[i][0].last;
        end else begin
          req_data[i*WL +: WL] = '0;
          req_last[i] = 1'b0;
        end
      end
      hs = req_valid & req_ready;
      if (hs != '0) hs_t = $time;
    end
  end

  // Monitor: checks characters, grant order, burst sizes, latencies and timeout pulses.
  initial begin
    bit   prev_start = 0, prev_gv = 0, prev_err = 0, pend_lat = 0;
    int   cur_n = 0, cur_exp_n = 0;
    logic [7:0] held = '0;
    time  rise_t = 0, fall_t = 0;
    tx_t  e;
    gr_t  g;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_start = 0; prev_gv = 0; prev_err = 0; pend_lat = 0;
      end else begin
        if (grant_valid && !prev_gv) begin
          if (exp_gr.size() == 0) chk("gr_extra", exp_gr.size(), 1);
          else begin
            g = exp_gr.pop_front();
            chk("gr_id", 32'(grant_id), 32'(g.id));
            cur_exp_n = int'(g.n);
          end
          if (pend_lat) chk("idle_lat", 32'(($time - fall_t) / 10), 1);
          pend_lat = 0;
          cur_n = 0;
        end
        if (tx_start && !prev_start) begin
          if (exp_tx.size() == 0) chk("tx_extra", exp_tx.size(), 1);
          else begin
            e = exp_tx.pop_front();
            chk("tx_data", 32'(tx_data), 32'(e.d));
            chk("tx_id", 32'(grant_id), 32'(e.id));
          end
          chk("tx_gv", 32'(grant_valid), 1);
          chk("acc_lat", 32'(($time - hs_t) / 10), 1);
          cur_n++;
          rise_t = $time;
          held = tx_data;
        end else if (tx_start) begin
          chk("tx_hold", 32'(tx_data), 32'(held));
        end
        if (!grant_valid && prev_gv) begin
          chk("burst_len", 32'(cur_n), 32'(cur_exp_n));
          pend_lat = any_rq();
          fall_t = $time;
        end
        if (err_timeout) begin
          err_cnt++;
          if (!tmo_mode) chk("err_spur", 32'(err_timeout), 0);
          else begin
            chk("tmo_lat", 32'(($time - rise_t) / 10), TMO);
            chk("tmo_start", 32'(tx_start), 0);
            chk("tmo_gv", 32'(grant_valid), 0);
          end
          if (prev_err) chk("err_width", 32'(prev_err), 0);
        end
        prev_start = tx_start;
        prev_gv = grant_valid;
        prev_err = err_timeout;
      end
    end
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    int ngr, n, bound;
    bit got;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_start", 32'(tx_start), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_rdy", 32'(req_ready), 0);
    chk("rst_gv", 32'(grant_valid), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_err", 32'(err_timeout), 0);
    reset = 1'b0;
    @(negedge clk);
    #2;

    // Burst cap: requester 0 streams 10, requester 2 waits behind 4.
    for (int j = 0; j < 10; j++) load(0, 8'(8'h50 + j), j == 9);
    load(2, 8'hA0, 1'b0);
    load(2, 8'hA1, 1'b1);
    predict(MB, ngr);
    wait_phase("burst");

    // Requesters 1 and 3 together, then 1 again.
    load(1, 8'h31, 1'b1);
    load(3, 8'h33, 1'b1);
    predict(MB, ngr);
    wait_phase("rr13");
    load(1, 8'h35, 1'b1);
    predict(MB, ngr);
    wait_phase("rr1");

    // Two-character message from requester 0.
    load(0, 8'h41, 1'b0);
    load(0, 8'h42, 1'b1);
    predict(MB, ngr);
    wait_phase("two");

    // Random traffic with pauses while owning the grant.
    pause_en = 1'b1;
    for (int p = 0; p < 6; p++) begin
      got = 1'b0;
      for (int i = 0; i < NR; i++) begin
        n = int'($urandom_range(0, 6));
        for (int j = 0; j < n; j++) begin
          load(i, 8'($urandom), (j == n - 1) || ($urandom_range(0, 3) == 0));
          got = 1'b1;
        end
      end
      if (!got) load(p % NR, 8'hEE, 1'b1);
      predict(MB, ngr);
      wait_phase("rand");
    end
    pause_en = 1'b0;

    // Requester 2 stalls 50 clocks mid-message.
    force_pause = 1'b1;
    load(2, 8'hC0, 1'b0);
    load(2, 8'hC1, 1'b0);
    load(2, 8'hC2, 1'b1);
    predict(MB, ngr);
    wait_phase("stall");
    chk("stall_used", 32'(force_pause), 0);

    // Transmitter never accepts: every start times out, messages truncated.
    tmo_mode = 1'b1;
    err_cnt = 0;
    load(0, 8'hE0, 1'b1);
    load(1, 8'hE1, 1'b0);
    load(1, 8'hE2, 1'b1);
    predict(1, ngr);
    wait_phase("tmo");
    chk("tmo_count", 32'(err_cnt), 32'(ngr));
    tmo_mode = 1'b0;
    err_cnt = 0;

    // Reset while a character is being sent.
    load(0, 8'hD0, 1'b0);
    load(0, 8'hD1, 1'b0);
    load(0, 8'hD2, 1'b1);
    predict(MB, ngr);
    bound = 0;
    while (!(grant_valid && !tx_ready && !tx_start) && bound < 1000) begin
      @(negedge clk);
      bound++;
    end
    chk("rst_reach", 32'(bound < 1000), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_start", 32'(tx_start), 0);
    chk("arst_data", 32'(tx_data), 0);
    chk("arst_rdy", 32'(req_ready), 0);
    chk("arst_gv", 32'(grant_valid), 0);
    chk("arst_gid", 32'(grant_id), 0);
    chk("arst_err", 32'(err_timeout), 0);
    for (int i = 0; i < NR; i++) rq[i].delete();
    exp_tx.delete();
    exp_gr.delete();
    m_last_grant = NR - 1;
    for (int i = 0; i < NR; i++) load(i, 8'(8'h60 + i), 1'b1);
    predict(MB, ngr);
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    chk("rel_start", 32'(tx_start), 0);
    chk("rel_gid", 32'(grant_id), 0);
    chk("rel_rdy", 32'(req_ready), 1);
    wait_phase("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
